// File: rtl/dm_abstract_seq.sv
// Abstract command sequencer for the debug module: checks Command writes and
// autoexec triggers, hands accepted commands to the hart, owns busy/cmderr.
module dm_abstract_seq #(
    parameter int ProgBufSize = 8,
    parameter int DataCount   = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dmactive_i,
    input  logic        cmd_valid_i,
    input  logic [31:0] cmd_i,
    input  logic        data_access_i,
    input  logic [3:0]  data_idx_i,
    input  logic        progbuf_access_i,
    input  logic [3:0]  progbuf_idx_i,
    input  logic [31:0] abstractauto_i,
    input  logic [2:0]  cmderr_clr_i,
    input  logic        halted_i,
    input  logic        ack_done_i,
    input  logic        ack_exception_i,
    output logic        going_o,
    output logic [31:0] cmd_o,
    output logic        busy_o,
    output logic [2:0]  cmderr_o
);

    typedef enum logic [1:0] {
        IDLE,
        GO,
        EXEC
    } state_e;

    localparam logic [2:0] ErrNone        = 3'd0;
    localparam logic [2:0] ErrBusy        = 3'd1;
    localparam logic [2:0] ErrNotSupported = 3'd2;
    localparam logic [2:0] ErrException   = 3'd3;
    localparam logic [2:0] ErrHaltResume  = 3'd4;

    localparam logic [4:0] DataLimit    = 5'(DataCount);
    localparam logic [4:0] ProgBufLimit = 5'(ProgBufSize);

    state_e      state;
    logic        data_hit;
    logic        progbuf_hit;
    logic        trigger;
    logic        busy_access;
    logic [31:0] eff_cmd;
    logic [2:0]  check_err;
    logic [2:0]  cmderr_cleared;

    // Progbuf autoexec bits live in the upper half of abstractauto.
    always_comb begin
        data_hit       = data_access_i && ({1'b0, data_idx_i} < DataLimit)
                         && abstractauto_i[{1'b0, data_idx_i}];
        progbuf_hit    = progbuf_access_i && ({1'b0, progbuf_idx_i} < ProgBufLimit)
                         && abstractauto_i[{1'b1, progbuf_idx_i}];
        trigger        = cmd_valid_i || data_hit || progbuf_hit;
        busy_access    = cmd_valid_i || data_access_i || progbuf_access_i;
        eff_cmd        = cmd_valid_i ? cmd_i : cmd_o;
        cmderr_cleared = cmderr_o & ~cmderr_clr_i;

        check_err = ErrNone;
        if (eff_cmd[31:24] != 8'h00) begin
            check_err = ErrNotSupported;
        end else if (eff_cmd[17] && (eff_cmd[22:21] != 2'b01)) begin
            check_err = ErrNotSupported;
        end else if (eff_cmd[17] && (eff_cmd[15:0] >= 16'h1020)) begin
            check_err = ErrNotSupported;
        end else if (!halted_i) begin
            check_err = ErrHaltResume;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            going_o  <= 1'b0;
            busy_o   <= 1'b0;
            cmderr_o <= ErrNone;
            cmd_o    <= 32'h0;
        end else if (!dmactive_i) begin
            state    <= IDLE;
            going_o  <= 1'b0;
            busy_o   <= 1'b0;
            cmderr_o <= ErrNone;
            cmd_o    <= 32'h0;
        end else begin
            going_o  <= 1'b0;
            cmderr_o <= cmderr_cleared;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_o <= cmd_i;
                    end
                    // A pending error blocks triggers until software clears it.
                    if (trigger && (cmderr_o == ErrNone)) begin
                        if (check_err != ErrNone) begin
                            cmderr_o <= check_err;
                        end else begin
                            state   <= GO;
                            going_o <= 1'b1;
                            busy_o  <= 1'b1;
                        end
                    end
                end
                GO: begin
                    state <= EXEC;
                    if (busy_access && (cmderr_cleared == ErrNone)) begin
                        cmderr_o <= ErrBusy;
                    end
                end
                EXEC: begin
                    if (busy_access && (cmderr_cleared == ErrNone)) begin
                        cmderr_o <= ErrBusy;
                    end
                    if (ack_exception_i) begin
                        if (cmderr_cleared == ErrNone) begin
                            cmderr_o <= ErrException;
                        end
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (ack_done_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_abstract_seq.sv
// Testbench for dm_abstract_seq: directed vector table for the corner cases,
// then randomized traffic against a behavioural model of the command rules.
module tb_dm_abstract_seq;

    localparam int ProgBufSize = 8;
    localparam int DataCount   = 2;
    localparam logic [31:0] CmdA = 32'h00231008;
    localparam logic [31:0] AA   = 32'h00010001;
    localparam logic [31:0] ALL  = 32'hFFFFFFFF;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        dmactive_i;
    logic        cmd_valid_i;
    logic [31:0] cmd_i;
    logic        data_access_i;
    logic [3:0]  data_idx_i;
    logic        progbuf_access_i;
    logic [3:0]  progbuf_idx_i;
    logic [31:0] abstractauto_i;
    logic [2:0]  cmderr_clr_i;
    logic        halted_i;
    logic        ack_done_i;
    logic        ack_exception_i;
    logic        going_o;
    logic [31:0] cmd_o;
    logic        busy_o;
    logic [2:0]  cmderr_o;

    int checks = 0;
    int errors = 0;

    dm_abstract_seq #(
        .ProgBufSize(ProgBufSize),
        .DataCount  (DataCount)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .dmactive_i      (dmactive_i),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_i           (cmd_i),
        .data_access_i   (data_access_i),
        .data_idx_i      (data_idx_i),
        .progbuf_access_i(progbuf_access_i),
        .progbuf_idx_i   (progbuf_idx_i),
        .abstractauto_i  (abstractauto_i),
        .cmderr_clr_i    (cmderr_clr_i),
        .halted_i        (halted_i),
        .ack_done_i      (ack_done_i),
        .ack_exception_i (ack_exception_i),
        .going_o         (going_o),
        .cmd_o           (cmd_o),
        .busy_o          (busy_o),
        .cmderr_o        (cmderr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        dmactive;
        logic        cmd_valid;
        logic [31:0] cmd;
        logic        data_access;
        logic [3:0]  data_idx;
        logic        progbuf_access;
        logic [3:0]  progbuf_idx;
        logic [31:0] aauto;
        logic [2:0]  clr;
        logic        halted;
        logic        done;
        logic        exc;
        logic        exp_going;
        logic [31:0] exp_cmd;
        logic        exp_busy;
        logic [2:0]  exp_err;
    } vec_t;

    vec_t vecs[$];

    logic        m_going;
    logic [31:0] m_cmd;
    logic        m_busy;
    logic [2:0]  m_err;

    function automatic void addVec(string name, logic dm, logic cv, logic [31:0] cmd,
                                   logic da, logic [3:0] di, logic pa, logic [3:0] pi,
                                   logic [31:0] aauto, logic [2:0] clr, logic h,
                                   logic done, logic exc, logic eg, logic [31:0] ecmd,
                                   logic eb, logic [2:0] ee);
        vec_t v;
        v.name = name; v.dmactive = dm; v.cmd_valid = cv; v.cmd = cmd;
        v.data_access = da; v.data_idx = di; v.progbuf_access = pa; v.progbuf_idx = pi;
        v.aauto = aauto; v.clr = clr; v.halted = h; v.done = done; v.exc = exc;
        v.exp_going = eg; v.exp_cmd = ecmd; v.exp_busy = eb; v.exp_err = ee;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        dmactive_i       = v.dmactive;
        cmd_valid_i      = v.cmd_valid;
        cmd_i            = v.cmd;
        data_access_i    = v.data_access;
        data_idx_i       = v.data_idx;
        progbuf_access_i = v.progbuf_access;
        progbuf_idx_i    = v.progbuf_idx;
        abstractauto_i   = v.aauto;
        cmderr_clr_i     = v.clr;
        halted_i         = v.halted;
        ack_done_i       = v.done;
        ack_exception_i  = v.exc;
    endtask

    task automatic checkOutput(input string name, input logic eg, input logic [31:0] ecmd,
                               input logic eb, input logic [2:0] ee);
        checks++;
        if (going_o !== eg || cmd_o !== ecmd || busy_o !== eb || cmderr_o !== ee) begin
            errors++;
            $display("[TB] FAIL %s: got going=%0b cmd=%08h busy=%0b cmderr=%0d, expected going=%0b cmd=%08h busy=%0b cmderr=%0d",
                     name, going_o, cmd_o, busy_o, cmderr_o, eg, ecmd, eb, ee);
        end
    endtask

    // Legality of a command, decoded from its field positions with plain arithmetic.
    function automatic logic [2:0] judge(logic [31:0] c, logic halted);
        int unsigned cmdtype  = c >> 24;
        int unsigned aarsize  = (c >> 20) & 7;
        int unsigned transfer = (c >> 17) & 1;
        int unsigned regno    = c & 32'hFFFF;
        if (cmdtype != 0) return 3'd2;
        if (transfer == 1 && !(aarsize == 2 || aarsize == 3)) return 3'd2;
        if (transfer == 1 && regno > 32'h101F) return 3'd2;
        if (!halted) return 3'd4;
        return 3'd0;
    endfunction

    task automatic modelStep();
        logic [2:0] old_err = m_err;
        logic [2:0] cleared = m_err & ~cmderr_clr_i;
        bit data_hit = data_access_i && (int'(data_idx_i) < DataCount)
                       && abstractauto_i[int'(data_idx_i)];
        bit pb_hit   = progbuf_access_i && (int'(progbuf_idx_i) < ProgBufSize)
                       && abstractauto_i[int'(progbuf_idx_i) + 16];
        bit any_access = cmd_valid_i || data_access_i || progbuf_access_i;
        if (!dmactive_i) begin
            m_going = 0; m_cmd = 0; m_busy = 0; m_err = 0;
        end else if (!m_busy) begin
            m_going = 0;
            m_err   = cleared;
            if (cmd_valid_i) m_cmd = cmd_i;
            if ((cmd_valid_i || data_hit || pb_hit) && old_err == 0) begin
                logic [2:0] e = judge(m_cmd, halted_i);
                if (e != 0) m_err = e;
                else begin
                    m_busy  = 1;
                    m_going = 1;
                end
            end
        end else begin
            bit executing = !m_going;
            m_going = 0;
            m_err   = cleared;
            if (any_access && cleared == 0) m_err = 1;
            if (executing && ack_exception_i) begin
                if (cleared == 0) m_err = 3;
                m_busy = 0;
            end else if (executing && ack_done_i) begin
                m_busy = 0;
            end
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        dmactive_i = 1; cmd_valid_i = 1; cmd_i = CmdA; data_access_i = 1; data_idx_i = 0;
        progbuf_access_i = 0; progbuf_idx_i = 0; abstractauto_i = AA; cmderr_clr_i = 0;
        halted_i = 1; ack_done_i = 0; ack_exception_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset", 0, 32'h0, 0, 3'd0);
        rst_ni = 1'b1;

        //       name                dm cv cmd           da di pa pi aauto clr h  dn ex   g cmd           b  err
        addVec("load",              1, 1, CmdA,         0, 0, 0, 0, AA,  0, 1, 0, 0,   1, CmdA,         1, 0);
        addVec("go_to_exec",        1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 0, 0,   0, CmdA,         1, 0);
        addVec("exec_hold",         1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 0, 0,   0, CmdA,         1, 0);
        addVec("done",              1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 1, 0,   0, CmdA,         0, 0);
        addVec("retrigger",         1, 1, CmdA,         0, 0, 0, 0, AA,  0, 1, 0, 0,   1, CmdA,         1, 0);
        addVec("ack_in_go",         1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 1, 0,   0, CmdA,         1, 0);
        addVec("done2",             1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 1, 0,   0, CmdA,         0, 0);
        addVec("not_halted",        1, 1, CmdA,         0, 0, 0, 0, AA,  0, 0, 0, 0,   0, CmdA,         0, 4);
        addVec("clr_halt",          1, 0, 0,            0, 0, 0, 0, AA,  7, 1, 0, 0,   0, CmdA,         0, 0);
        addVec("mem_cmd",           1, 1, 32'h02000000, 0, 0, 0, 0, AA,  0, 1, 0, 0,   0, 32'h02000000, 0, 2);
        addVec("clr_mem",           1, 0, 0,            0, 0, 0, 0, AA,  7, 1, 0, 0,   0, 32'h02000000, 0, 0);
        addVec("aarsize4",          1, 1, 32'h00421000, 0, 0, 0, 0, AA,  0, 1, 0, 0,   0, 32'h00421000, 0, 2);
        addVec("clr_size",          1, 0, 0,            0, 0, 0, 0, AA,  7, 1, 0, 0,   0, 32'h00421000, 0, 0);
        addVec("regno2000",         1, 1, 32'h00222000, 0, 0, 0, 0, AA,  0, 1, 0, 0,   0, 32'h00222000, 0, 2);
        addVec("cmd_while_err",     1, 1, CmdA,         0, 0, 0, 0, AA,  0, 1, 0, 0,   0, CmdA,         0, 2);
        addVec("err_sticky",        1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 0, 0,   0, CmdA,         0, 2);
        addVec("clr_regno",         1, 0, 0,            0, 0, 0, 0, AA,  7, 1, 0, 0,   0, CmdA,         0, 0);
        addVec("auto_data0",        1, 0, 0,            1, 0, 0, 0, AA,  0, 1, 0, 0,   1, CmdA,         1, 0);
        addVec("auto_data0_exec",   1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 0, 0,   0, CmdA,         1, 0);
        addVec("auto_data0_done",   1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 1, 0,   0, CmdA,         0, 0);
        addVec("auto_pb0",          1, 0, 0,            0, 0, 1, 0, AA,  0, 1, 0, 0,   1, CmdA,         1, 0);
        addVec("auto_pb0_exec",     1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 0, 0,   0, CmdA,         1, 0);
        addVec("auto_pb0_done",     1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 1, 0,   0, CmdA,         0, 0);
        addVec("data2_bound",       1, 0, 0,            1, 2, 0, 0, ALL, 0, 1, 0, 0,   0, CmdA,         0, 0);
        addVec("data3",             1, 0, 0,            1, 3, 0, 0, ALL, 0, 1, 0, 0,   0, CmdA,         0, 0);
        addVec("pb8_bound",         1, 0, 0,            0, 0, 1, 8, ALL, 0, 1, 0, 0,   0, CmdA,         0, 0);
        addVec("pb9",               1, 0, 0,            0, 0, 1, 9, ALL, 0, 1, 0, 0,   0, CmdA,         0, 0);
        addVec("auto_data1",        1, 0, 0,            1, 1, 0, 0, ALL, 0, 1, 0, 0,   1, CmdA,         1, 0);
        addVec("auto_data1_exec",   1, 0, 0,            0, 0, 0, 0, ALL, 0, 1, 0, 0,   0, CmdA,         1, 0);
        addVec("auto_data1_done",   1, 0, 0,            0, 0, 0, 0, ALL, 0, 1, 1, 0,   0, CmdA,         0, 0);
        addVec("auto_pb7",          1, 0, 0,            0, 0, 1, 7, ALL, 0, 1, 0, 0,   1, CmdA,         1, 0);
        addVec("auto_pb7_exec",     1, 0, 0,            0, 0, 0, 0, ALL, 0, 1, 0, 0,   0, CmdA,         1, 0);
        addVec("auto_pb7_done",     1, 0, 0,            0, 0, 0, 0, ALL, 0, 1, 1, 0,   0, CmdA,         0, 0);
        addVec("busy_start",        1, 1, CmdA,         0, 0, 0, 0, AA,  0, 1, 0, 0,   1, CmdA,         1, 0);
        addVec("busy_cmd",          1, 1, 32'h12345678, 0, 0, 0, 0, AA,  0, 1, 0, 0,   0, CmdA,         1, 1);
        addVec("busy_data",         1, 0, 0,            1, 0, 0, 0, AA,  0, 1, 0, 0,   0, CmdA,         1, 1);
        addVec("exc_and_done",      1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 1, 1,   0, CmdA,         0, 1);
        addVec("clr_busy",          1, 0, 0,            0, 0, 0, 0, AA,  7, 1, 0, 0,   0, CmdA,         0, 0);
        addVec("exc_start",         1, 1, CmdA,         0, 0, 0, 0, AA,  0, 1, 0, 0,   1, CmdA,         1, 0);
        addVec("exc_exec",          1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 0, 0,   0, CmdA,         1, 0);
        addVec("exc_both",          1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 1, 1,   0, CmdA,         0, 3);
        addVec("clr_exc",           1, 0, 0,            0, 0, 0, 0, AA,  7, 1, 0, 0,   0, CmdA,         0, 0);
        addVec("deact_start",       1, 1, CmdA,         0, 0, 0, 0, AA,  0, 1, 0, 0,   1, CmdA,         1, 0);
        addVec("deact_exec",        1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 0, 0,   0, CmdA,         1, 0);
        addVec("dmactive_low",      0, 0, 0,            0, 0, 0, 0, AA,  0, 1, 0, 0,   0, 32'h0,        0, 0);
        addVec("late_done",         1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 1, 0,   0, 32'h0,        0, 0);
        addVec("late_exc",          1, 0, 0,            0, 0, 0, 0, AA,  0, 1, 0, 1,   0, 32'h0,        0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(posedge clk_i);
            #1;
            checkOutput(vecs[i].name, vecs[i].exp_going, vecs[i].exp_cmd,
                        vecs[i].exp_busy, vecs[i].exp_err);
        end

        // Randomized traffic; acks and cmderr clears only in cycles without DMI accesses.
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        m_going = 0; m_cmd = 0; m_busy = 0; m_err = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [31:0] pool [8];
            bit quiet;
            pool[0] = CmdA;         pool[1] = 32'h00331000; pool[2] = 32'h00220FFF;
            pool[3] = 32'h0022101F; pool[4] = 32'h00221020; pool[5] = 32'h00421000;
            pool[6] = 32'h00001020; pool[7] = $urandom;
            if (cyc % 200 == 0) abstractauto_i = $urandom;
            dmactive_i       = ($urandom_range(0, 99) != 0);
            cmd_valid_i      = ($urandom_range(0, 9) == 0);
            cmd_i            = pool[$urandom_range(0, 7)];
            data_access_i    = ($urandom_range(0, 9) == 0);
            data_idx_i       = 4'($urandom_range(0, 15));
            progbuf_access_i = ($urandom_range(0, 9) == 0);
            progbuf_idx_i    = 4'($urandom_range(0, 15));
            halted_i         = ($urandom_range(0, 99) < 85);
            quiet            = !(cmd_valid_i || data_access_i || progbuf_access_i);
            ack_done_i       = quiet && ($urandom_range(0, 4) == 0);
            ack_exception_i  = quiet && ($urandom_range(0, 11) == 0);
            cmderr_clr_i     = quiet && ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            modelStep();
            @(posedge clk_i);
            #1;
            checkOutput($sformatf("random_%0d", cyc), m_going, m_cmd, m_busy, m_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
